// File: rtl/sumador_checker.sv
// Response checker for the 4-bit registered adder/subtractor: golden model, LAT-deep expected pipeline,
// per-cycle compare, saturating counters and a FAIL FSM. Optional first-failure snapshot: SUMADOR_CHK_SNAP_EN.
module sumador_checker #(
    parameter int LAT   = 1,
    parameter int ERR_W = 8,
    parameter int CHK_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             Cin,
    input  logic [3:0]       Q,
    input  logic             RCO,
    output logic [3:0]       EXP_Q,
    output logic             EXP_RCO,
    output logic             VALID,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [CHK_W-1:0] CHK_CNT,
    output logic [10:0]      FAIL_SNAP
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0] m_q_q, m_q_d;
    logic       m_rco_q, m_rco_d;
    logic       m_known_q, m_known_d;
    logic [4:0] sum5, diff5;

    // Each stage holds {rco, q}; stage LAT-1 is what the DUT should be showing now.
    logic [LAT-1:0][4:0] stage_val_q, stage_val_d;
    logic [LAT-1:0]      stage_known_q, stage_known_d;

    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
    logic             mismatch;

    assign sum5  = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    assign diff5 = {1'b0, A} - {1'b0, B} - {4'b0000, Cin};

    always_comb begin
        m_q_d     = m_q_q;
        m_rco_d   = m_rco_q;
        m_known_d = m_known_q;
        if (ENB) begin
            case (MODO)
                2'b01: begin
                    {m_rco_d, m_q_d} = sum5;
                    m_known_d        = 1'b1;
                end
                2'b10: begin
                    {m_rco_d, m_q_d} = diff5;
                    m_known_d        = 1'b1;
                end
                2'b11: begin
                    m_q_d     = 4'b0000;
                    m_rco_d   = 1'b0;
                    m_known_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stage 0 takes the freshly updated model so LAT=1 lines up with a one-edge DUT.
    always_comb begin
        stage_val_d      = stage_val_q;
        stage_known_d    = stage_known_q;
        stage_val_d[0]   = {m_rco_d, m_q_d};
        stage_known_d[0] = m_known_d;
        for (int i = 1; i < LAT; i++) begin
            stage_val_d[i]   = stage_val_q[i-1];
            stage_known_d[i] = stage_known_q[i-1];
        end
    end

    assign EXP_Q   = stage_val_q[LAT-1][3:0];
    assign EXP_RCO = stage_val_q[LAT-1][4];
    assign VALID   = stage_known_q[LAT-1];

    assign mismatch = VALID && ({RCO, Q} != stage_val_q[LAT-1]);

    always_comb begin
        err_d        = mismatch;
        err_sticky_d = err_sticky_q | mismatch;
        err_cnt_d    = err_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if (VALID && (chk_cnt_q != {CHK_W{1'b1}})) begin
            chk_cnt_d = chk_cnt_q + CHK_W'(1);
        end
    end

    // A mismatch on the very first valid compare goes straight to FAIL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNKNOWN: begin
                if (VALID) begin
                    state_d = mismatch ? ST_FAIL : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (mismatch) begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_UNKNOWN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_UNKNOWN;
            m_q_q         <= '0;
            m_rco_q       <= 1'b0;
            m_known_q     <= 1'b0;
            stage_val_q   <= '0;
            stage_known_q <= '0;
            err_q         <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_cnt_q     <= '0;
            chk_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            m_q_q         <= m_q_d;
            m_rco_q       <= m_rco_d;
            m_known_q     <= m_known_d;
            stage_val_q   <= stage_val_d;
            stage_known_q <= stage_known_d;
            err_q         <= err_d;
            err_sticky_q  <= err_sticky_d;
            err_cnt_q     <= err_cnt_d;
            chk_cnt_q     <= chk_cnt_d;
        end
    end

    assign ERR        = err_q;
    assign ERR_STICKY = err_sticky_q;
    assign ERR_CNT    = err_cnt_q;
    assign CHK_CNT    = chk_cnt_q;

`ifdef SUMADOR_CHK_SNAP_EN
    logic [LAT-1:0][1:0] stage_modo_q, stage_modo_d;
    logic [10:0]         snap_q, snap_d;

    always_comb begin
        stage_modo_d    = stage_modo_q;
        stage_modo_d[0] = MODO;
        for (int i = 1; i < LAT; i++) begin
            stage_modo_d[i] = stage_modo_q[i-1];
        end
        snap_d = snap_q;
        if (mismatch && (state_q != ST_FAIL)) begin
            snap_d = {stage_modo_q[LAT-1], Q, RCO, EXP_Q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_modo_q <= '0;
            snap_q       <= '0;
        end else begin
            stage_modo_q <= stage_modo_d;
            snap_q       <= snap_d;
        end
    end

    assign FAIL_SNAP = snap_q;
`else
    assign FAIL_SNAP = 11'd0;
`endif

endmodule
